// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory/IO port between the pipeline MEM stage (cpu_*) and a
// secondary requester (dbg_*). The CPU has priority; the secondary requester gets one
// forced slot after MAX_WAIT consecutive blocked cycles, freezing the pipeline.
module dmem_port_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 8,   // legal range 1..255
    parameter int unsigned CW       = 16
) (
    input  logic          clock,
    input  logic          resetn,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,

    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic [CW-1:0] stall_cnt
);

    typedef enum logic {
        StCpu,
        StForce
    } state_e;

    // wait_cnt value on the last blocked cycle before a forced slot
    localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

    state_e        state_q, state_d;
    logic [7:0]    wait_q, wait_d;
    logic          dbg_own;
    logic          dbg_rvalid_q;
    logic [DW-1:0] dbg_rdata_q;
    logic [CW-1:0] stall_cnt_q;

    // Owner selection and port muxing; a non-requesting owner never writes
    always_comb begin
        dbg_own   = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we & cpu_req;

        if (state_q == StForce) begin
            dbg_own = dbg_req;
        end else begin
            dbg_own = dbg_req & ~cpu_req;
        end

        if (dbg_own) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_we    = dbg_we & dbg_req;
        end
    end

    assign dbg_gnt    = dbg_own;
    assign cpu_stall  = dbg_own & cpu_req;
    assign cpu_rdata  = mem_rdata;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign stall_cnt  = stall_cnt_q;

    // Next-state: count CPU-won contention cycles, force one dbg slot at the limit
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;

        unique case (state_q)
            StCpu: begin
                if (cpu_req && dbg_req) begin
                    if (wait_q == WaitLast) begin
                        state_d = StForce;
                        wait_d  = 8'd0;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end else begin
                    wait_d = 8'd0;
                end
            end
            StForce: begin
                // Single-cycle slot whether or not dbg still requests
                state_d = StCpu;
                wait_d  = 8'd0;
            end
            default: begin
                state_d = StCpu;
                wait_d  = 8'd0;
            end
        endcase
    end

    // Arbitration state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StCpu;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Registered dbg read return; data held between reads
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            dbg_rvalid_q <= dbg_own & ~dbg_we;
            if (dbg_own && !dbg_we) begin
                dbg_rdata_q <= mem_rdata;
            end
        end
    end

    // Saturating count of pipeline stall cycles
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
        end else if (cpu_stall && (stall_cnt_q != {CW{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus randomized traffic,
// compared each cycle against a behavioural model of the arbitration rules.
module tb_dmem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Main DUT (MAX_WAIT=8, CW=16)
    logic          resetn;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [15:0]   stall_cnt;

    logic [DW-1:0] mem [16];
    assign mem_rdata = mem[mem_addr[3:0]];

    dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW), .CW(16)) u_dut (
        .clock(clock), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_cnt(stall_cnt)
    );

    // Small DUT (MAX_WAIT=1, CW=4) for reset-in-slot and saturation checks
    logic          s_resetn;
    logic          s_cpu_req, s_dbg_req;
    logic [DW-1:0] s_cpu_rdata, s_dbg_rdata, s_mem_wdata;
    logic [AW-1:0] s_mem_addr;
    logic          s_cpu_stall, s_dbg_gnt, s_dbg_rvalid, s_mem_we;
    logic [3:0]    s_stall_cnt;

    dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(1), .CW(4)) u_small (
        .clock(clock), .resetn(s_resetn),
        .cpu_req(s_cpu_req), .cpu_we(1'b0), .cpu_addr(32'h0), .cpu_wdata(32'h0),
        .cpu_rdata(s_cpu_rdata), .cpu_stall(s_cpu_stall),
        .dbg_req(s_dbg_req), .dbg_we(1'b0), .dbg_addr(32'h4), .dbg_wdata(32'h0),
        .dbg_gnt(s_dbg_gnt), .dbg_rvalid(s_dbg_rvalid), .dbg_rdata(s_dbg_rdata),
        .mem_addr(s_mem_addr), .mem_we(s_mem_we), .mem_wdata(s_mem_wdata),
        .mem_rdata(32'h1234_5678), .stall_cnt(s_stall_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int            blocked;     // consecutive cycles dbg waited behind the CPU
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;
    logic [15:0]   m_scnt;
    logic [DW-1:0] refm [16];
    logic          last_gnt, last_stall;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs are already driven (just after a negedge). Check, advance model, commit write.
    task automatic tick(input string tag);
        logic          e_gnt, e_stall, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic          wr_en;
        logic [3:0]    wr_a;
        logic [DW-1:0] wr_d;
        #1;
        e_gnt   = dbg_req && (!cpu_req || blocked == MW);
        e_stall = e_gnt && cpu_req;
        if (e_gnt) begin
            e_addr = dbg_addr; e_we = dbg_we; e_wd = dbg_wdata;
        end else begin
            e_addr = cpu_addr; e_we = cpu_we && cpu_req; e_wd = cpu_wdata;
        end
        check_eq({tag, "_gnt"},    32'(dbg_gnt),    32'(e_gnt));
        check_eq({tag, "_stall"},  32'(cpu_stall),  32'(e_stall));
        check_eq({tag, "_addr"},   mem_addr,        e_addr);
        check_eq({tag, "_we"},     32'(mem_we),     32'(e_we));
        if (e_we) check_eq({tag, "_wdata"}, mem_wdata, e_wd);
        check_eq({tag, "_rdata"},  cpu_rdata,       refm[e_addr[3:0]]);
        check_eq({tag, "_rvalid"}, 32'(dbg_rvalid), 32'(m_rvalid));
        if (m_rvalid) check_eq({tag, "_dbgrd"}, dbg_rdata, m_rdata);
        check_eq({tag, "_scnt"},   32'(stall_cnt),  32'(m_scnt));

        wr_en = mem_we; wr_a = mem_addr[3:0]; wr_d = mem_wdata;

        m_rvalid = e_gnt && !dbg_we;
        if (m_rvalid) m_rdata = refm[e_addr[3:0]];
        if (e_we) refm[e_addr[3:0]] = e_wd;
        if (e_stall && m_scnt != 16'hFFFF) m_scnt++;
        if (blocked == MW || !(cpu_req && dbg_req) || e_gnt) blocked = 0;
        else blocked++;
        last_gnt   = e_gnt;
        last_stall = e_stall;

        @(posedge clock);
        #1;
        if (wr_en) mem[wr_a] = wr_d;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] a,
                           input logic [31:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic [31:0] a,
                           input logic [31:0] d);
        dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    initial begin
        logic [31:0] v;
        resetn = 1'b0; s_resetn = 1'b0;
        s_cpu_req = 1'b0; s_dbg_req = 1'b0;
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            mem[i] = v; refm[i] = v;
        end
        v = 32'hCAFE_0001; mem[0] = v; refm[0] = v;
        blocked = 0; m_rvalid = 1'b0; m_rdata = '0; m_scnt = '0;
        last_gnt = 1'b0; last_stall = 1'b0;

        // Reset state
        #1;
        check_eq("rst_rvalid", 32'(dbg_rvalid), 32'd0);
        check_eq("rst_rdata",  dbg_rdata,       32'd0);
        check_eq("rst_scnt",   32'(stall_cnt),  32'd0);
        check_eq("rst_stall",  32'(cpu_stall),  32'd0);
        @(negedge clock);
        resetn = 1'b1;

        // Idle CPU, dbg read of 0x10
        set_dbg(1'b1, 1'b0, 32'h10, 32'h0);
        tick("t2a");
        check_eq("t2_rvalid", 32'(dbg_rvalid), 32'd1);
        check_eq("t2_rdata",  dbg_rdata,       32'hCAFE_0001);
        @(negedge clock);
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        tick("t2b");

        // Continuous CPU traffic: grant lands in cycle MAX_WAIT
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            set_cpu(1'b1, 1'b0, 32'h24, 32'h0);
            set_dbg(i <= 8, 1'b0, 32'h8, 32'h0);
            #1;
            check_eq("t3_gnt",   32'(dbg_gnt),   32'(i == 8));
            check_eq("t3_stall", 32'(cpu_stall), 32'(i == 8));
            tick("t3");
        end
        check_eq("t3_scnt", 32'(stall_cnt), 32'd1);

        // Stalled CPU store must not reach memory until the following cycle
        v = 32'hAAAA_0000; mem[0] = v; refm[0] = v;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i < 8) set_cpu(1'b1, 1'b0, 32'h24, 32'h0);
            else       set_cpu(1'b1, 1'b1, 32'h20, 32'h5);
            set_dbg(i <= 8, 1'b0, 32'h4, 32'h0);
            tick("t4");
            if (i == 8) check_eq("t4_nowr", mem[0], 32'hAAAA_0000);
            if (i == 9) check_eq("t4_wr",   mem[0], 32'h5);
        end

        // dbg drops its request as the forced slot begins
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i == 8) set_cpu(1'b1, 1'b1, 32'h28, 32'h77);
            else        set_cpu(1'b1, 1'b0, 32'h24, 32'h0);
            set_dbg(i != 8, 1'b0, 32'h4, 32'h0);
            #1;
            if (i == 8) begin
                check_eq("t5_gnt",   32'(dbg_gnt),   32'd0);
                check_eq("t5_stall", 32'(cpu_stall), 32'd0);
            end
            if (i == 9) check_eq("t5_back", 32'(dbg_gnt), 32'd0);
            tick("t5");
            if (i == 8) check_eq("t5_wr", mem[8], 32'h77);
        end
        @(negedge clock);
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        tick("t5z");

        // Randomized traffic obeying both hold rules
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (!last_stall) begin
                set_cpu(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                        32'($urandom_range(0, 15)), $urandom);
            end
            if (!(dbg_req && !last_gnt)) begin
                set_dbg($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                        32'($urandom_range(0, 15)), $urandom);
            end
            tick("rnd");
        end
        @(negedge clock);
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset asserted in the middle of a forced slot (MAX_WAIT=1)
        s_cpu_req = 1'b1; s_dbg_req = 1'b1; s_resetn = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_eq("t1_rv_pre", 32'(s_dbg_rvalid), 32'd1);
        @(posedge clock);
        #1;
        check_eq("t1_gnt_pre",   32'(s_dbg_gnt),   32'd1);
        check_eq("t1_stall_pre", 32'(s_cpu_stall), 32'd1);
        check_eq("t1_scnt_pre",  32'(s_stall_cnt), 32'd1);
        #2;
        s_resetn = 1'b0;
        #1;
        check_eq("t1_gnt",    32'(s_dbg_gnt),    32'd0);
        check_eq("t1_stall",  32'(s_cpu_stall),  32'd0);
        check_eq("t1_scnt",   32'(s_stall_cnt),  32'd0);
        check_eq("t1_rvalid", 32'(s_dbg_rvalid), 32'd0);

        // Saturation of a 4-bit stall counter
        @(negedge clock);
        s_resetn = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        check_eq("t6_mid", 32'(s_stall_cnt), 32'd5);
        repeat (34) @(posedge clock);
        #1;
        check_eq("t6_sat", 32'(s_stall_cnt), 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
